// File: rtl/video_timing_pkg.sv
// Shared timing constants, FSM state and control-bundle types for the 720p60 raster.
package video_timing_pkg;

    // Horizontal raster, in pixel clocks
    localparam int H_ACTIVE      = 1280;
    localparam int H_FRONT_PORCH = 110;
    localparam int H_SYNC_LEN    = 40;
    localparam int H_BACK_PORCH  = 220;
    localparam int H_TOTAL       = H_ACTIVE + H_FRONT_PORCH + H_SYNC_LEN + H_BACK_PORCH;
    localparam int H_SYNC_START  = H_ACTIVE + H_FRONT_PORCH;
    localparam int H_SYNC_END    = H_SYNC_START + H_SYNC_LEN - 1;

    // Vertical raster, in lines
    localparam int V_ACTIVE      = 720;
    localparam int V_FRONT_PORCH = 5;
    localparam int V_SYNC_LEN    = 5;
    localparam int V_BACK_PORCH  = 20;
    localparam int V_TOTAL       = V_ACTIVE + V_FRONT_PORCH + V_SYNC_LEN + V_BACK_PORCH;
    localparam int V_SYNC_START  = V_ACTIVE + V_FRONT_PORCH;
    localparam int V_SYNC_END    = V_SYNC_START + V_SYNC_LEN - 1;

    // Counter widths seen on the fetch-side ports
    localparam int H_W = 11;
    localparam int V_W = 10;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOPPING
    } vt_state_t;

    // Encoder-side control bundle carried through the pipeline delay
    typedef struct packed {
        logic active;
        logic hsync;
        logic vsync;
    } vt_ctrl_t;

    // Inclusive window test used for both sync pulses
    function automatic logic in_window(input logic [10:0] pos,
                                       input logic [10:0] lo,
                                       input logic [10:0] hi);
        return (pos >= lo) && (pos <= hi);
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register that realigns control signals with the pixel pipeline.
// DEPTH of zero collapses to a plain wire.
module sync_delay_line #(
    parameter int  DEPTH = 4,
    parameter type T     = logic
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  T     data_in,
    output T     data_out
);

    if (DEPTH == 0) begin : g_wire
        logic unused_clk_rst;
        assign unused_clk_rst = clk_in ^ rst_n_in;
        assign data_out       = data_in;
    end else begin : g_shift
        T stage_q [DEPTH];
        T stage_d [DEPTH];

        // Each stage takes the previous one; stage 0 takes the live input
        always_comb begin
            stage_d[0] = data_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end

        // Shift every clock; reset flushes the whole line to zero
        always_ff @(posedge clk_in or negedge rst_n_in) begin
            if (!rst_n_in) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= '0;
                end
            end else begin
                stage_q <= stage_d;
            end
        end

        assign data_out = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/video_timing_ctrl.sv
// Raster timing generator for the HDMI output path. Fetch-side counters and request
// run directly from the registered raster position; encoder-side enables and syncs are
// delayed by PIPE_DELAY so they meet the pixel data at the TMDS encoders.
// Raster sizes default to 720p60 and are only overridden for reduced-size simulation.
module video_timing_ctrl
    import video_timing_pkg::*;
#(
    parameter int PIPE_DELAY = 4,
    parameter int FC_W       = 6,
    parameter int H_ACT      = H_ACTIVE,
    parameter int H_FP       = H_FRONT_PORCH,
    parameter int H_SW       = H_SYNC_LEN,
    parameter int H_BP       = H_BACK_PORCH,
    parameter int V_ACT      = V_ACTIVE,
    parameter int V_FP       = V_FRONT_PORCH,
    parameter int V_SW       = V_SYNC_LEN,
    parameter int V_BP       = V_BACK_PORCH
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    input  logic            enable_in,
    input  logic            pix_valid_in,
    output logic [10:0]     hcount_out,
    output logic [9:0]      vcount_out,
    output logic            pix_req_out,
    output logic            active_draw_out,
    output logic            hor_sync_out,
    output logic            vert_sync_out,
    output logic            new_frame_out,
    output logic [FC_W-1:0] frame_count_out,
    output logic            running_out,
    output logic            underflow_out
);

    localparam int H_TOT = H_ACT + H_FP + H_SW + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SW + V_BP;

    localparam logic [10:0] H_LAST  = 11'(H_TOT - 1);
    localparam logic [10:0] H_ACT_L = 11'(H_ACT);
    localparam logic [10:0] H_SS    = 11'(H_ACT + H_FP);
    localparam logic [10:0] H_SE    = 11'(H_ACT + H_FP + H_SW - 1);
    localparam logic [9:0]  V_LAST  = 10'(V_TOT - 1);
    localparam logic [9:0]  V_ACT_L = 10'(V_ACT);
    localparam logic [9:0]  V_SS    = 10'(V_ACT + V_FP);
    localparam logic [9:0]  V_SE    = 10'(V_ACT + V_FP + V_SW - 1);

    vt_state_t       state_q, state_d;
    logic [10:0]     h_q, h_d;
    logic [9:0]      v_q, v_d;
    logic [FC_W-1:0] frame_count_q, frame_count_d;
    logic            underflow_q, underflow_d;

    logic            running;
    logic            pix_req;
    logic            new_frame;
    logic            end_of_frame;
    vt_ctrl_t        ctrl_raw;
    vt_ctrl_t        ctrl_enc;

    assign end_of_frame = (h_q == H_LAST) && (v_q == V_LAST);

    // FSM state register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: stopping only lands in IDLE on the last pixel of a frame
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (enable_in) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!enable_in) begin
                    state_d = STOPPING;
                end
            end
            STOPPING: begin
                if (enable_in) begin
                    state_d = RUN;
                end else if (end_of_frame) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: fetch-side request, raw control bundle and frame-start strobe
    always_comb begin
        running        = (state_q != IDLE);
        pix_req        = running && (h_q < H_ACT_L) && (v_q < V_ACT_L);
        ctrl_raw       = '0;
        ctrl_raw.active = pix_req;
        ctrl_raw.hsync  = running && in_window(h_q, H_SS, H_SE);
        ctrl_raw.vsync  = running && in_window({1'b0, v_q}, {1'b0, V_SS}, {1'b0, V_SE});
        new_frame      = running && (h_q == H_ACT_L) && (v_q == V_ACT_L);
    end

    // Raster position advances every non-idle cycle and wraps at the frame end
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (running) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 11'd1;
            end
        end
    end

    // Frame counter bumps on the frame-start strobe; underflow set beats clear
    always_comb begin
        frame_count_d = frame_count_q;
        underflow_d   = underflow_q;
        if (new_frame) begin
            frame_count_d = frame_count_q + FC_W'(1);
            underflow_d   = 1'b0;
        end
        if (ctrl_enc.active && !pix_valid_in) begin
            underflow_d = 1'b1;
        end
    end

    // Datapath registers
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            h_q           <= '0;
            v_q           <= '0;
            frame_count_q <= '0;
            underflow_q   <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            frame_count_q <= frame_count_d;
            underflow_q   <= underflow_d;
        end
    end

    sync_delay_line #(
        .DEPTH (PIPE_DELAY),
        .T     (vt_ctrl_t)
    ) u_ctrl_delay (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .data_in  (ctrl_raw),
        .data_out (ctrl_enc)
    );

    assign hcount_out      = h_q;
    assign vcount_out      = v_q;
    assign pix_req_out     = pix_req;
    assign active_draw_out = ctrl_enc.active;
    assign hor_sync_out    = ctrl_enc.hsync;
    assign vert_sync_out   = ctrl_enc.vsync;
    assign new_frame_out   = new_frame;
    assign frame_count_out = frame_count_q;
    assign running_out     = running;
    assign underflow_out   = underflow_q;

endmodule
